// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM DMA state encoding and transfer length.
// OAM_DMA_ALIGN_EN adds the ALIGN state used for odd-cycle alignment.
package ppu_pkg;

    localparam int OAM_DMA_LEN = 256;

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } oam_dma_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_READ,
        ST_WRITE
    } oam_dma_state_t;
`endif

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to DMA_REG_ADDR copies one 256-byte page
// of CPU space into PPU OAM while stalling the CPU.
// Ports: clk, reset (sync, active high); cpu_we/cpu_addr/cpu_data_in trigger;
// dma_mem_addr/dma_mem_re/mem_data_in source reads; cpu_stall; oam_dma/
// oam_addr/oam_data OAM write port.
// Macro OAM_DMA_ALIGN_EN enables the extra ALIGN cycle on odd parity.
module oam_dma_ctrl
    import ppu_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    output logic [15:0] dma_mem_addr,
    output logic        dma_mem_re,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_stall,
    output logic        oam_dma,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_DMA_LEN - 1);

    oam_dma_state_t state;
    oam_dma_state_t state_nx;
    logic [7:0]     idx;
    logic [7:0]     page;
    logic           parity;
    logic           trig;

    assign trig = cpu_we && (cpu_addr == DMA_REG_ADDR) && (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= 8'h00;
            page   <= 8'h00;
            parity <= 1'b0;
        end else begin
            state  <= state_nx;
            parity <= ~parity;
            if (trig) begin
                page <= cpu_data_in;
                idx  <= 8'h00;
            end else if (state == ST_WRITE) begin
                // 8-bit wrap: after byte 255 idx is back at 0
                idx <= idx + 8'h01;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        cpu_stall    = 1'b1;
        dma_mem_re   = 1'b0;
        dma_mem_addr = 16'h0000;
        oam_dma      = 1'b0;
        oam_addr     = 8'h00;
        oam_data     = 8'h00;
        case (state)
            ST_IDLE: begin
                cpu_stall = 1'b0;
                if (trig) state_nx = ST_HALT;
            end
            ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_nx = parity ? ST_ALIGN : ST_READ;
`else
                state_nx = ST_READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            ST_ALIGN: begin
                state_nx = ST_READ;
            end
`endif
            ST_READ: begin
                dma_mem_re   = 1'b1;
                // page byte is never incremented: no carry out of idx
                dma_mem_addr = {page, idx};
                state_nx     = ST_WRITE;
            end
            ST_WRITE: begin
                oam_dma  = 1'b1;
                oam_addr = idx;
                oam_data = mem_data_in;
                state_nx = (idx == LAST_IDX) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_nx  = ST_IDLE;
                cpu_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: reference model of the transfer
// schedule feeds expectation queues consumed by a negedge monitor.
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic [15:0] dma_mem_addr;
    logic        dma_mem_re;
    logic [7:0]  mem_data_in;
    logic        cpu_stall;
    logic        oam_dma;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;

    oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014)) dut (
        .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_data_in(cpu_data_in), .dma_mem_addr(dma_mem_addr),
        .dma_mem_re(dma_mem_re), .mem_data_in(mem_data_in),
        .cpu_stall(cpu_stall), .oam_dma(oam_dma), .oam_addr(oam_addr),
        .oam_data(oam_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];

    always @(posedge clk)
        if (dma_mem_re) mem_data_in <= mem[dma_mem_addr];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: cycles of stall remaining, parity of current cycle
    int          rem = 0;
    bit          halt_pend = 0;
    bit          p = 0;
    bit          aborted = 0;
    logic [15:0] wq[$];
    logic [15:0] rq[$];
    int          sq[$];

    always @(posedge clk) begin
        if (reset) begin
            if (rem > 0) aborted = 1;
            rem = 0;
            halt_pend = 0;
            p = 0;
            wq.delete();
            rq.delete();
            sq.delete();
        end else begin
            if (rem > 0) begin
                if (halt_pend) begin
                    halt_pend = 0;
                    if (ALIGN_EN && p) begin
                        rem++;
                        sq.push_back(514);
                    end else begin
                        sq.push_back(513);
                    end
                end
                rem--;
            end else if (cpu_we && cpu_addr == 16'h4014) begin
                rem = 513;
                halt_pend = 1;
                for (int i = 0; i < 256; i++) begin
                    logic [15:0] a;
                    a = {cpu_data_in, 8'(i)};
                    rq.push_back(a);
                    wq.push_back({8'(i), mem[a]});
                end
            end
            p = ~p;
        end
    end

    bit mon_en = 0;
    int run = 0;
    int wrun = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk(cpu_stall === (rem > 0), "stall", int'(cpu_stall), int'(rem > 0));
            if (oam_dma === 1'b1) begin
                wrun++;
                if (wq.size() == 0) begin
                    chk(0, "extra_oam_write", int'(oam_addr), 0);
                end else begin
                    logic [15:0] e;
                    e = wq.pop_front();
                    chk({oam_addr, oam_data} === e, "oam_write",
                        int'({oam_addr, oam_data}), int'(e));
                end
            end else begin
                chk(oam_dma === 1'b0 && oam_addr === 8'h00 && oam_data === 8'h00,
                    "oam_idle", int'({oam_dma, oam_addr, oam_data}), 0);
            end
            if (dma_mem_re === 1'b1) begin
                if (rq.size() == 0) begin
                    chk(0, "extra_read", int'(dma_mem_addr), 0);
                end else begin
                    logic [15:0] e;
                    e = rq.pop_front();
                    chk(dma_mem_addr === e, "read_addr", int'(dma_mem_addr), int'(e));
                end
            end else begin
                chk(dma_mem_re === 1'b0 && dma_mem_addr === 16'h0000,
                    "read_idle", int'(dma_mem_addr), 0);
            end
            if (cpu_stall === 1'b1) begin
                run++;
            end else if (run > 0) begin
                if (aborted) begin
                    aborted = 0;
                end else if (sq.size() == 0) begin
                    chk(0, "stall_len_unexpected", run, 0);
                end else begin
                    int e;
                    e = sq.pop_front();
                    chk(run == e, "stall_len", run, e);
                    chk(wrun == 256, "write_count", wrun, 256);
                end
                run = 0;
                wrun = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        cpu_we = 1'b1;
        cpu_addr = a;
        cpu_data_in = d;
        cyc(1);
        cpu_we = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data_in = 8'h00;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (rem != 0 && n < 2000) begin
            cyc(1);
            n++;
        end
        chk(n < 2000, nm, n, 2000);
    endtask

    task automatic wait_parity(input bit v);
        if (p != v) cyc(1);
    endtask

    task automatic drain_check(input string nm);
        cyc(3);
        chk(wq.size() == 0 && rq.size() == 0 && sq.size() == 0, nm,
            wq.size() + rq.size() + sq.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data_in = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        cyc(1);
        mon_en = 1;
        cyc(2);
        chk(cpu_stall === 1'b0 && oam_dma === 1'b0 && dma_mem_re === 1'b0,
            "reset_state", int'({cpu_stall, oam_dma, dma_mem_re}), 0);
        reset = 1'b0;

        // stray writes elsewhere must not start anything
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if (a == 16'h4014) a = 16'h4015;
            bus_write(a, 8'($urandom));
        end
        cyc(2);

        // page 2 from an even cycle
        wait_parity(0);
        bus_write(16'h4014, 8'h02);
        wait_idle("timeout_page2");
        drain_check("drain_page2");

        // both trigger parities
        wait_parity(0);
        bus_write(16'h4014, 8'($urandom));
        wait_idle("timeout_par0");
        wait_parity(1);
        bus_write(16'h4014, 8'($urandom));
        wait_idle("timeout_par1");
        drain_check("drain_parity");

        // retrigger at stall cycle 100 is ignored
        bus_write(16'h4014, 8'h03);
        cyc(99);
        bus_write(16'h4014, 8'h55);
        wait_idle("timeout_retrig");
        drain_check("drain_retrig");

        // page FF: no carry into the page byte
        bus_write(16'h4014, 8'hFF);
        wait_idle("timeout_pageff");
        drain_check("drain_pageff");

        // reset at stall cycle 300 aborts
        bus_write(16'h4014, 8'($urandom));
        cyc(299);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        @(negedge clk);
        chk(cpu_stall === 1'b0 && oam_dma === 1'b0, "abort",
            int'({cpu_stall, oam_dma}), 0);
        cyc(1);
        bus_write(16'h4014, 8'h07);
        wait_idle("timeout_after_abort");
        drain_check("drain_after_abort");

        // reset wins over a simultaneous trigger
        reset = 1'b1;
        bus_write(16'h4014, 8'h09);
        reset = 1'b0;
        cyc(3);
        chk(cpu_stall === 1'b0, "reset_priority", int'(cpu_stall), 0);

        // back-to-back in the first IDLE cycle
        bus_write(16'h4014, 8'h10);
        wait_idle("timeout_b2b_a");
        bus_write(16'h4014, 8'h11);
        wait_idle("timeout_b2b_b");
        drain_check("drain_b2b");

        // randomized transfers with stray mid-transfer triggers
        for (int t = 0; t < 3; t++) begin
            cyc($urandom_range(0, 5));
            bus_write(16'h4014, 8'($urandom));
            cyc($urandom_range(1, 400));
            bus_write(16'h4014, 8'($urandom));
            wait_idle("timeout_rand");
        end
        drain_check("drain_rand");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, the CPU address whose write starts a transfer.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cpu_we, input, 1, CPU bus write strobe, one cycle per write.
REQ-005 SHALL have port cpu_addr, input, 16, CPU bus address.
REQ-006 SHALL have port cpu_data_in, input, 8, CPU write data; supplies the source page number.
REQ-007 SHALL have port dma_mem_addr, output, 16, CPU-space read address driven during a transfer.
REQ-008 SHALL have port dma_mem_re, output, 1, read request, one cycle per byte.
REQ-009 SHALL have port mem_data_in, input, 8, read data, valid the cycle after dma_mem_re.
REQ-010 SHALL have port cpu_stall, output, 1, holds the CPU off the bus while high.
REQ-011 SHALL have port oam_dma, output, 1, OAM write strobe to the PPU.
REQ-012 SHALL have port oam_addr, output, 8, OAM byte index.
REQ-013 SHALL have port oam_data, output, 8, OAM write data.

Function
REQ-014 SHALL start a transfer when cpu_we=1, cpu_addr==DMA_REG_ADDR and state==IDLE; page latched from cpu_data_in.
REQ-015 SHALL ignore trigger writes while state!=IDLE.
REQ-016 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE.
REQ-017 SHALL move IDLE->HALT on trigger; HALT->ALIGN if parity==1 (ALIGN enabled, REQ-029), else HALT->READ; ALIGN->READ; READ->WRITE; WRITE->READ if idx!=255, else WRITE->IDLE.
REQ-018 SHALL assert cpu_stall in every non-IDLE state, i.e. from the cycle after the trigger through the final WRITE inclusive.
REQ-019 SHALL, in READ, drive dma_mem_re=1 and dma_mem_addr={page,idx}; otherwise dma_mem_re=0 and dma_mem_addr=16'h0000.
REQ-020 SHALL, in WRITE, drive oam_dma=1, oam_addr=idx and oam_data=mem_data_in, then increment idx (8-bit, 255->0 wrap).
REQ-021 SHALL hold oam_dma=0 outside WRITE; oam_addr and oam_data are 0 when oam_dma=0.
REQ-022 SHALL copy exactly 256 bytes, {page,00}..{page,FF}, with no carry into the page byte (page FF reads FF00..FFFF).
REQ-023 SHALL keep a 1-bit parity flop toggling every cycle since reset; parity==1 marks an odd cycle.
REQ-024 SHALL stall exactly 513 cycles when no ALIGN occurs and 514 when ALIGN occurs.
REQ-025 SHALL accept a new trigger in the same cycle the controller returns to IDLE (the first IDLE cycle).

Reset
REQ-026 SHALL on reset force state=IDLE, idx=0, page=0, parity=0, cpu_stall=0, dma_mem_re=0, dma_mem_addr=0, oam_dma=0, oam_addr=0, oam_data=0.
REQ-027 SHALL abort any transfer on reset mid-transfer, with no further OAM writes and cpu_stall low the cycle after reset is sampled.
REQ-028 SHALL let reset take priority over a simultaneous trigger write.

Configuration
REQ-029 SHALL honour macro OAM_DMA_ALIGN_EN: when defined, the ALIGN state is used per REQ-017. When undefined, HALT always goes to READ, the ALIGN state is not present and the stall is always 513 cycles.

Structure
REQ-030 SHALL take the state enum (oam_dma_state_t) and the constant OAM_DMA_LEN=256 from shared package ppu_pkg.
REQ-031 SHALL be a single module with no sub-modules; the byte counter is inline.

Verification
REQ-032 SHALL check: reset, then write 8'h02 to 16'h4014 on an even cycle -> 513 stall cycles; OAM[i]==mem[16'h0200+i] for all i; 256 oam_dma pulses.
REQ-033 SHALL check: trigger on an odd cycle with OAM_DMA_ALIGN_EN defined -> 514 stall cycles; with it undefined -> 513.
REQ-034 SHALL check: second write to 16'h4014 at stall cycle 100 -> ignored; source page unchanged; total 256 writes.
REQ-035 SHALL check: page 8'hFF -> last read address 16'hFFFF; no read at 16'h0000.
REQ-036 SHALL check: reset asserted at stall cycle 300 -> cpu_stall=0 and oam_dma=0 next cycle; a new trigger afterwards completes normally.
REQ-037 SHALL check: trigger in the first IDLE cycle after a transfer -> second transfer starts; cpu_stall low for exactly one cycle between transfers.
